// File: rtl/axil_master_arbiter.sv
// axil_master_arbiter: shares one AXI4-Lite master port between two requesters, one whole read or write at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module axil_master_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic [2:0]          s0_awprot,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  output logic                s0_bvalid,
  input  logic                s0_bready,
  input  logic [ADDR_W-1:0]   s0_araddr,
  input  logic [2:0]          s0_arprot,
  input  logic                s0_arvalid,
  output logic                s0_arready,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic                s0_rvalid,
  input  logic                s0_rready,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [2:0]          s1_awprot,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  output logic                s1_bvalid,
  input  logic                s1_bready,
  input  logic [ADDR_W-1:0]   s1_araddr,
  input  logic [2:0]          s1_arprot,
  input  logic                s1_arvalid,
  output logic                s1_arready,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic                s1_rvalid,
  input  logic                s1_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [1:0]          gnt,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state, state_n;
  logic [1:0] owner, owner_n;
  logic ar_done, aw_done, w_done, ar_done_n, aw_done_n, w_done_n;
  logic req0, req1, sel1, o0, o1, rd, wr, bw;
  assign req0 = s0_arvalid | s0_awvalid;
  assign req1 = s1_arvalid | s1_awvalid;
  assign o0 = owner[0];
  assign o1 = owner[1];
  assign rd = state == READ;
  assign wr = state == WRITE;
  assign bw = aw_done & w_done;
`ifdef ARB_ROUND_ROBIN_EN
  logic last;
  assign sel1 = req1 & (~req0 | ~last);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) last <= 1'b1;
    else if (state == IDLE && (req0 | req1)) last <= sel1;
`else
  assign sel1 = ~req0 & req1;
`endif
  // Request fields are zero whenever no owner is latched.
  assign m_awaddr  = ({ADDR_W{o0}} & s0_awaddr) | ({ADDR_W{o1}} & s1_awaddr);
  assign m_awprot  = ({3{o0}} & s0_awprot) | ({3{o1}} & s1_awprot);
  assign m_araddr  = ({ADDR_W{o0}} & s0_araddr) | ({ADDR_W{o1}} & s1_araddr);
  assign m_arprot  = ({3{o0}} & s0_arprot) | ({3{o1}} & s1_arprot);
  assign m_wdata   = ({DATA_W{o0}} & s0_wdata) | ({DATA_W{o1}} & s1_wdata);
  assign m_wstrb   = ({(DATA_W/8){o0}} & s0_wstrb) | ({(DATA_W/8){o1}} & s1_wstrb);
  assign m_arvalid = rd & ~ar_done & (o1 ? s1_arvalid : s0_arvalid);
  assign m_rready  = rd & (o1 ? s1_rready : s0_rready);
  assign m_awvalid = wr & ~aw_done & (o1 ? s1_awvalid : s0_awvalid);
  assign m_wvalid  = wr & ~w_done & (o1 ? s1_wvalid : s0_wvalid);
  assign m_bready  = wr & bw & (o1 ? s1_bready : s0_bready);
  assign s0_arready = o0 & rd & m_arready & ~ar_done;
  assign s1_arready = o1 & rd & m_arready & ~ar_done;
  assign s0_rvalid  = o0 & rd & m_rvalid & ar_done;
  assign s1_rvalid  = o1 & rd & m_rvalid & ar_done;
  assign s0_awready = o0 & wr & m_awready & ~aw_done;
  assign s1_awready = o1 & wr & m_awready & ~aw_done;
  assign s0_wready  = o0 & wr & m_wready & ~w_done;
  assign s1_wready  = o1 & wr & m_wready & ~w_done;
  assign s0_bvalid  = o0 & wr & m_bvalid & bw;
  assign s1_bvalid  = o1 & wr & m_bvalid & bw;
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign gnt  = owner;
  assign busy = state != IDLE;
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    ar_done_n = ar_done | (m_arvalid & m_arready);
    aw_done_n = aw_done | (m_awvalid & m_awready);
    w_done_n  = w_done | (m_wvalid & m_wready);
    if (state == IDLE) begin
      ar_done_n = 1'b0;
      aw_done_n = 1'b0;
      w_done_n  = 1'b0;
      if (req0 | req1) begin
        owner_n = sel1 ? 2'b10 : 2'b01;
        state_n = (sel1 ? s1_arvalid : s0_arvalid) ? READ : WRITE;
      end
    end else if ((m_rvalid & m_rready & ar_done) | (m_bvalid & m_bready)) begin
      state_n = IDLE;
      owner_n = 2'b00;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state   <= IDLE;
      owner   <= 2'b00;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      ar_done <= ar_done_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
endmodule
